k6502_seq: RTL



---
 rtl/k6502_seq_if.sv | 29 ++
 rtl/k6502_seq.sv | 104 ++++++++++
 2 files changed

// File: rtl/k6502_seq_if.sv
// k6502 sequencer bus bundle: stall/sync controls, opcode bus, interrupt pins and decoder outputs.
// Carries no logic and adds no latency; it only groups the wires.
// There is no backpressure; rdy is the only stall input and the sequencer obeys it directly.
interface k6502_seq_if #(
  parameter int CYCLE_W = 6,
  parameter int CNT_W   = 16
);
  logic               rdy;
  logic               sync_next;
  logic [7:0]         data_in;
  logic               sr_i;
  logic               nmi_n;
  logic               irq_n;
  logic [7:0]         ir;
  logic [CYCLE_W-1:0] cycle;
  logic [2:0]         intr;
  logic               err;
  logic [CNT_W-1:0]   instr_cnt;

  modport master (
    output rdy, sync_next, data_in, sr_i, nmi_n, irq_n,
    input  ir, cycle, intr, err, instr_cnt
  );

  modport slave (
    input  rdy, sync_next, data_in, sr_i, nmi_n, irq_n,
    output ir, cycle, intr, err, instr_cnt
  );
endinterface

// File: rtl/k6502_seq.sv
// k6502 instruction sequencer: instruction register, one-hot cycle counter and RST/NMI/IRQ entry arbitration.
// All outputs are registered; an opcode present in the sync_next cycle appears on ir one clock later, at C_0.
// rdy=0 freezes all sequencing state; only the NMI edge detector keeps sampling.
module k6502_seq #(
  parameter int         CYCLE_W   = 6,
  parameter logic [7:0] FORCED_OP = 8'hEA,
  parameter int         CNT_W     = 16
) (
  input logic        clk,
  input logic        rst_n,
  k6502_seq_if.slave bus
);

  // Each sequence state is encoded exactly as its intr select value {rst, nmi, irq}.
  typedef enum logic [2:0] {
    SEQ_NORM = 3'b000,
    SEQ_IRQ  = 3'b001,
    SEQ_NMI  = 3'b010,
    SEQ_RST  = 3'b100
  } seq_e;

  localparam logic [CYCLE_W-1:0] C_FIRST = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] C_LAST  = C_FIRST << (CYCLE_W - 1);

  seq_e               seq_q, seq_d;
  logic [7:0]         ir_q, ir_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               nmi_q;
  logic               nmi_pend_q, nmi_pend_d;
  logic               nmi_fall;

  // NMI pin history; it samples every clock so that edges arriving during a stall are not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nmi_q <= 1'b1;
    else        nmi_q <= bus.nmi_n;
  end

  assign nmi_fall = nmi_q & ~bus.nmi_n;

  // Next-state logic: boundary arbitration, cycle stepping and overrun recovery.
  always_comb begin
    seq_d      = seq_q;
    ir_d       = ir_q;
    cycle_d    = cycle_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    nmi_pend_d = nmi_pend_q | nmi_fall;
    if (bus.rdy) begin
      if (bus.sync_next) begin
        cycle_d = C_FIRST;
        if (nmi_pend_q) begin
          seq_d      = SEQ_NMI;
          ir_d       = 8'h00;
          // A fresh edge on the same clock re-arms the pending flag.
          nmi_pend_d = nmi_fall;
        end else if (!bus.irq_n && !bus.sr_i) begin
          seq_d = SEQ_IRQ;
          ir_d  = 8'h00;
        end else begin
          seq_d = SEQ_NORM;
          ir_d  = bus.data_in;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (cycle_q == C_LAST) begin
        // Microcode ran past the last cycle: flag it and force a NOP refetch.
        // Pending interrupts stay armed for the next boundary.
        err_d   = 1'b1;
        cycle_d = C_FIRST;
        ir_d    = FORCED_OP;
        seq_d   = SEQ_NORM;
      end else begin
        cycle_d = cycle_q << 1;
      end
    end
  end

  // Sequencing state registers; reset restarts the sequencer in the RST sequence at C_0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q      <= SEQ_RST;
      ir_q       <= 8'h00;
      cycle_q    <= C_FIRST;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      nmi_pend_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      ir_q       <= ir_d;
      cycle_q    <= cycle_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign bus.ir        = ir_q;
  assign bus.cycle     = cycle_q;
  assign bus.intr      = seq_q;
  assign bus.err       = err_q;
  assign bus.instr_cnt = cnt_q;

endmodule
